// File: rtl/permutation_scheduler_pkg.sv
// Shared types and constants for the ASCON permutation scheduler and its round datapath.
// The state is five 64-bit words, word 0 in the most significant position.
package permutation_scheduler_pkg;

    typedef logic [0:4][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_perm_fsm;

    localparam logic [7:0] ROUND_CONST [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational ASCON round: constant addition, bit-sliced S-box layer, linear diffusion.
module permutation_round
    import permutation_scheduler_pkg::*;
(
    input  logic [319:0] state,
    input  logic [3:0]   round,
    output logic [319:0] next_state
);

    type_state   s_add;
    type_state   s_out;
    logic [7:0]  rc;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        rc = (round < 4'd12) ? ROUND_CONST[round] : 8'h00;
        s_add = type_state'(state);
        s_add[2][7:0] = s_add[2][7:0] ^ rc;

        // S-box applied to all 64 columns at once, x0 being the column MSB
        x0 = s_add[0] ^ s_add[4];
        x1 = s_add[1];
        x2 = s_add[2] ^ s_add[1];
        x3 = s_add[3];
        x4 = s_add[4] ^ s_add[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        s_out[0] = x0 ^ ror64(x0, ROT_A[0]) ^ ror64(x0, ROT_B[0]);
        s_out[1] = x1 ^ ror64(x1, ROT_A[1]) ^ ror64(x1, ROT_B[1]);
        s_out[2] = x2 ^ ror64(x2, ROT_A[2]) ^ ror64(x2, ROT_B[2]);
        s_out[3] = x3 ^ ror64(x3, ROT_A[3]) ^ ror64(x3, ROT_B[3]);
        s_out[4] = x4 ^ ror64(x4, ROT_A[4]) ^ ror64(x4, ROT_B[4]);
        next_state = s_out;
    end

endmodule

// File: rtl/permutation_scheduler.sv
// Sequences ASCON p^12 / p^6 over the state register, one round per clock.
//   state | meaning
//   IDLE  | waiting for start_i, state register holds the last result
//   RUN   | one round applied per edge, counter = round applied next
//   DONE  | single cycle with done_o high, start_i ignored
module permutation_scheduler
    import permutation_scheduler_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_A - 1);
    localparam logic [3:0] START_B    = 4'(ROUNDS_A - ROUNDS_B);

    type_perm_fsm fsm;
    logic [319:0] state_q;
    logic [319:0] round_out;
    logic [3:0]   counter;

    permutation_round u_round (
        .state      (state_q),
        .round      (counter),
        .next_state (round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm     <= IDLE;
            state_q <= '0;
            counter <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_q <= state_i;
                        counter <= mode_i ? START_B : 4'd0;
                        busy_o  <= 1'b1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    // counter parks on the last round so round_o reads 11 afterwards
                    if (counter == LAST_ROUND) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        fsm    <= DONE;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    fsm    <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    fsm    <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign round_o = counter;

endmodule

// File: tb/tb_permutation_scheduler.sv
// Randomized bench for permutation_scheduler against a table-driven ASCON reference model.
module tb_permutation_scheduler;

    logic         clock_i;
    logic         reset_i;
    logic         start_i;
    logic         mode_i;
    logic [319:0] state_i;
    logic [319:0] state_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_pass   = 0;
    int done_count = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [319:0] VEC_A = 320'h80400c0600000000_8a55114d1cb6a9a2_be263d4d7aecaa0f_4ed0ec0b98c529b7_c8cddf37bcd0284a;
    localparam logic [319:0] VEC_B = 320'ha71b22fa2d0f5150_b11e0a9a608e0016_076f27ad4d99d506_a72ac1ad8440b0b7_0657b0d6eaf9c1c4;

    permutation_scheduler dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .state_i (state_i),
        .state_o (state_o),
        .round_o (round_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) if (done_o) done_count++;

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] w [5];
        logic [4:0]  col;
        for (int i = 0; i < 5; i++) w[i] = s[319 - 64 * i -: 64];
        w[2][7:0] = w[2][7:0] ^ c;
        for (int j = 0; j < 64; j++) begin
            col = {w[0][j], w[1][j], w[2][j], w[3][j], w[4][j]};
            col = SBOX[col];
            w[0][j] = col[4];
            w[1][j] = col[3];
            w[2][j] = col[2];
            w[3][j] = col[1];
            w[4][j] = col[0];
        end
        w[0] = w[0] ^ rr(w[0], 19) ^ rr(w[0], 28);
        w[1] = w[1] ^ rr(w[1], 61) ^ rr(w[1], 39);
        w[2] = w[2] ^ rr(w[2], 1)  ^ rr(w[2], 6);
        w[3] = w[3] ^ rr(w[3], 10) ^ rr(w[3], 17);
        w[4] = w[4] ^ rr(w[4], 7)  ^ rr(w[4], 41);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [319:0] t;
        t = s;
        for (int r = 12 - n; r < 12; r++) t = ref_round(t, 8'((15 - r) * 16 + r));
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic run_one(input logic m, input logic [319:0] s, input bit poke);
        int first;
        logic [319:0] exp;
        first = m ? 6 : 0;
        exp = ref_perm(s, 12 - first);
        start_i = 1'b1;
        mode_i  = m;
        state_i = s;
        @(negedge clock_i);
        start_i = 1'b0;
        mode_i  = 1'($urandom);
        state_i = rand320();
        for (int r = first; r < 12; r++) begin
            check_val("round_o", 320'(round_o), 320'(r));
            check_val("busy_run", 320'(busy_o), 320'(1));
            check_val("done_run", 320'(done_o), 320'(0));
            start_i = poke && (r == 3 || r == 11);
            state_i = rand320();
            @(negedge clock_i);
        end
        check_val("done_pulse", 320'(done_o), 320'(1));
        check_val("busy_done", 320'(busy_o), 320'(0));
        check_val("round_last", 320'(round_o), 320'(11));
        check_val("result", state_o, exp);
        start_i = poke;
        @(negedge clock_i);
        start_i = 1'b0;
        check_val("done_clear", 320'(done_o), 320'(0));
        check_val("busy_idle", 320'(busy_o), 320'(0));
        check_val("result_hold", state_o, exp);
    endtask

    initial begin
        int cnt0;
        logic [319:0] v [64];

        reset_i = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        state_i = '0;
        repeat (2) @(negedge clock_i);
        check_val("rst_state", state_o, '0);
        check_val("rst_round", 320'(round_o), 320'(0));
        check_val("rst_busy", 320'(busy_o), 320'(0));
        check_val("rst_done", 320'(done_o), 320'(0));
        reset_i = 1'b0;
        @(negedge clock_i);

        // asynchronous reset in the middle of a p^12 run
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = rand320();
        @(negedge clock_i);
        start_i = 1'b0;
        for (int k = 0; k < 20 && round_o != 4'd5; k++) @(negedge clock_i);
        check_val("reach_round5", 320'(round_o), 320'(5));
        reset_i = 1'b1;
        #1;
        check_val("amid_state", state_o, '0);
        check_val("amid_busy", 320'(busy_o), 320'(0));
        check_val("amid_round", 320'(round_o), 320'(0));
        check_val("amid_done", 320'(done_o), 320'(0));
        @(negedge clock_i);
        reset_i = 1'b0;
        cnt0 = done_count;
        repeat (20) @(negedge clock_i);
        check_val("no_done_after_rst", 320'(done_count), 320'(cnt0));
        check_val("idle_after_rst", 320'(busy_o), 320'(0));

        run_one(1'b0, VEC_A, 1'b0);
        run_one(1'b1, VEC_B, 1'b0);
        cnt0 = done_count;
        run_one(1'b0, VEC_A, 1'b1);
        check_val("single_done", 320'(done_count - cnt0), 320'(1));

        // one round from an all-zero state in p^6 mode uses constant 0x96
        start_i = 1'b1;
        mode_i  = 1'b1;
        state_i = '0;
        @(negedge clock_i);
        start_i = 1'b0;
        @(negedge clock_i);
        check_val("first_round_idx", 320'(round_o), 320'(7));
        check_val("round_c96", state_o, ref_round('0, 8'h96));
        repeat (5) @(negedge clock_i);
        check_val("zero_p6_done", 320'(done_o), 320'(1));
        check_val("zero_p6", state_o, ref_perm('0, 6));
        @(negedge clock_i);

        for (int i = 0; i < 6; i++) run_one(1'($urandom), rand320(), 1'($urandom));

        // start held high: accepts every 14 cycles, each using that cycle's state_i
        start_i = 1'b1;
        mode_i  = 1'b0;
        v[0] = rand320();
        state_i = v[0];
        for (int n = 1; n < 46; n++) begin
            @(negedge clock_i);
            check_val("b2b_done", 320'(done_o), 320'(n % 14 == 13));
            if (n % 14 == 13) check_val("b2b_result", state_o, ref_perm(v[n - 13], 12));
            v[n] = rand320();
            state_i = v[n];
        end
        start_i = 1'b0;
        repeat (20) @(negedge clock_i);
        check_val("b2b_idle", 320'(busy_o), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
